// File: rtl/processor.sv
// Multicycle 16-bit core: eight general registers, one adder/subtractor and
// a four-step sequencer. The caller supplies one instruction word per
// four-cycle slot. The last value placed on the internal bus is held on
// the bus output, which is the only way results (including OUT) leave the core.
module processor (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] iin,
  output logic [15:0] bus
);

  localparam int DATA_W = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OUT = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_REP = 3'b111;

  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

  step_t                    step;
  logic [DATA_W-1:0]        ir;
  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] g;
  logic [DATA_W-1:0]        r [8];

  logic [2:0]        op;
  logic [2:0]        rx;
  logic [2:0]        ry;
  logic [DATA_W-1:0] imm;

  assign op  = ir[15:13];
  assign rx  = ir[12:10];
  assign ry  = ir[9:7];
  assign imm = {6'd0, ir[9:0]};

  // Modulo 2^16 add or two's-complement subtract; no carry or flags are kept.
  function automatic logic signed [DATA_W-1:0] addsub(
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] y,
    input logic                     sub
  );
    return sub ? (x - y) : (x + y);
  endfunction

  // Step sequencer and datapath: every state element is cleared by reset, so
  // an instruction interrupted by reset leaves no partial register write.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      step <= T0;
      ir   <= '0;
      a    <= '0;
      g    <= '0;
      bus  <= '0;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else begin
      case (step)
        T0: begin
          ir   <= iin;
          step <= T1;
        end
        T1: begin
          step <= T2;
          case (op)
            OP_ADD, OP_SUB: begin
              a   <= r[rx];
              bus <= r[rx];
            end
            OP_LDI: begin
              r[rx] <= imm;
              bus   <= imm;
            end
            OP_REP: begin
              r[rx] <= r[ry];
              bus   <= r[ry];
            end
            OP_OUT: bus <= r[rx];
            default: ;
          endcase
        end
        T2: begin
          step <= T3;
          if (op == OP_ADD || op == OP_SUB) begin
            g   <= addsub(a, r[ry], op == OP_SUB);
            bus <= r[ry];
          end
        end
        default: begin
          step <= T0;
          if (op == OP_ADD || op == OP_SUB) begin
            r[rx] <= g;
            bus   <= g;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_processor.sv
// Bench for processor: directed programs plus random instruction streams.
// Expected bus values come from an instruction-level model of the ISA and
// are queued per slot; a monitor compares them as each slot progresses.
module tb_processor;

  logic        clock  = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] iin    = 16'h0000;
  logic [15:0] bus;

  processor dut (
    .clock  (clock),
    .resetn (resetn),
    .iin    (iin),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] word;
    logic [15:0] t1;
    logic [15:0] fin;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_r [8];
  logic [15:0] m_bus;
  int          edges;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_bus = 16'h0000;
  endtask

  // ISA-level meaning of one instruction: bus value after step T1 and at slot end.
  task automatic model_exec(input logic [15:0] w, output logic [15:0] t1v, output logic [15:0] fin);
    logic [2:0]  op;
    logic [2:0]  x;
    logic [2:0]  y;
    logic [15:0] rx_old;
    logic [15:0] ry_old;
    op = w[15:13];
    x  = w[12:10];
    y  = w[9:7];
    rx_old = m_r[x];
    ry_old = m_r[y];
    case (op)
      3'b000: begin t1v = rx_old; fin = rx_old + ry_old; m_r[x] = fin; end
      3'b001: begin t1v = rx_old; fin = rx_old - ry_old; m_r[x] = fin; end
      3'b101: begin fin = {6'd0, w[9:0]}; t1v = fin; m_r[x] = fin; end
      3'b111: begin fin = ry_old; t1v = fin; m_r[x] = fin; end
      3'b100: begin fin = rx_old; t1v = fin; end
      default: begin fin = m_bus; t1v = m_bus; end
    endcase
    m_bus = fin;
  endtask

  task automatic issue(input logic [15:0] w);
    exp_t e;
    @(negedge clock);
    iin = w;
    e.word = w;
    model_exec(w, e.t1, e.fin);
    q.push_back(e);
    repeat (4) @(posedge clock);
  endtask

  // Rising edges since reset release; slot boundaries fall on multiples of four.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) edges <= 0;
    else         edges <= edges + 1;
  end

  // Monitor: after T1 compare against the head entry, at slot end pop and compare.
  always @(negedge clock) begin
    if (resetn && edges > 0 && q.size() > 0) begin
      if (edges % 4 == 2) check($sformatf("t1_bus[%h]", q[0].word), {16'd0, bus}, {16'd0, q[0].t1});
      if (edges % 4 == 0) begin
        exp_t e;
        e = q.pop_front();
        check($sformatf("slot_bus[%h]", e.word), {16'd0, bus}, {16'd0, e.fin});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prog [$];
    model_reset();
    #1 check("reset_bus", {16'd0, bus}, 32'd0);
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;

    // Reference program, then NOPs that must leave bus at 72.
    prog = '{16'hA022, 16'hA432, 16'h0080, 16'hA83E, 16'h2100, 16'h0080, 16'hEC00, 16'h8C00,
             16'h4000, 16'h6000, 16'hC000, 16'h8C00};
    foreach (prog[i]) issue(prog[i]);

    // Wraparound through repeated doubling.
    issue(16'hB3FF);
    repeat (6) issue(16'h1200);
    issue(16'hB440);
    issue(16'h1280);
    issue(16'h9000);

    // Underflow and self-referencing operations.
    prog = '{16'hB800, 16'hBC01, 16'h3B80, 16'h9800, 16'hA405, 16'h0480, 16'h8400, 16'h2480, 16'h8400};
    foreach (prog[i]) issue(prog[i]);

    // Abort an ADD after its T2 step with an asynchronous reset.
    issue(16'hA022);
    issue(16'hA432);
    @(negedge clock);
    iin = 16'h0080;
    repeat (3) @(posedge clock);
    #2 resetn = 1'b0;
    #1 check("abort_bus", {16'd0, bus}, 32'd0);
    check("abort_queue", q.size(), 32'd0);
    model_reset();
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
    issue(16'h8000);
    issue(16'h8400);
    issue(16'h9C00);

    // Random instruction stream.
    for (int i = 0; i < 80; i++) issue(16'($urandom()));
    for (int i = 0; i < 8; i++) issue({3'b100, 3'(i), 10'd0});

    @(negedge clock);
    #1 check("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
